// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler; word_valid flags the handshake that completes a word.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int BYTES  = bytes_per_word(DATA_WIDTH);
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

    logic [LANE_W-1:0]     lane_r;
    logic [DATA_WIDTH-1:0] asm_r;
    logic [DATA_WIDTH-1:0] asm_s;

    // Merge the incoming byte into its lane so a completed word is visible on the same cycle.
    always_comb begin
        asm_s = asm_r;
        asm_s[{lane_r, 3'b000} +: 8] = in_data;
    end

    assign word       = asm_s;
    assign word_valid = in_valid && (lane_r == LAST_LANE);

    // Lane counter and partial-word register; a finished word restarts at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r <= '0;
            asm_r  <= '0;
        end else if (clr) begin
            lane_r <= '0;
            asm_r  <= '0;
        end else if (in_valid) begin
            if (lane_r == LAST_LANE) begin
                lane_r <= '0;
                asm_r  <= '0;
            end else begin
                lane_r <= lane_r + LANE_W'(1);
                asm_r  <= asm_s;
            end
        end else begin
            lane_r <= lane_r;
            asm_r  <= asm_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: holds the core, optionally zero-fills instruction RAM, streams a program, releases the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  WORD_ADDR_W = 10,
    localparam int BYTES       = bytes_per_word(DATA_WIDTH),
    localparam int BYTE_ADDR_W = WORD_ADDR_W + $clog2(BYTES)
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_L,
    input  logic                   start,
    input  logic                   skip_clear,
    input  logic [WORD_ADDR_W:0]   len_words,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   mem_we,
    output logic [BYTE_ADDR_W-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   core_hold_L,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [31:0]            checksum
);

    localparam int LEN_W = WORD_ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_W  = LEN_W'(1) << WORD_ADDR_W;
    localparam logic [LEN_W-1:0] LAST_IDX = DEPTH_W - LEN_W'(1);

    state_t                 state_r, state_s;
    logic [LEN_W-1:0]       len_eff_r, len_eff_s;
    logic [LEN_W-1:0]       idx_r, idx_s;
    logic                   overflow_r, overflow_s;
    logic [31:0]            checksum_r, checksum_s;
    logic                   mem_we_r, mem_we_s;
    logic [BYTE_ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_WIDTH-1:0]  mem_wdata_r, mem_wdata_s;
    logic                   byte_ready_r, byte_ready_s;
    logic                   core_hold_r, core_hold_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;

    logic                   hs_s;
    logic                   start_acc_s;
    logic                   word_valid_s;
    logic [DATA_WIDTH-1:0]  word_s;

    function automatic logic [BYTE_ADDR_W-1:0] word_to_byte_addr(input logic [LEN_W-1:0] idx);
        return BYTE_ADDR_W'(idx[WORD_ADDR_W-1:0]) * BYTE_ADDR_W'(BYTES);
    endfunction

    assign hs_s        = byte_valid && byte_ready_r;
    assign start_acc_s = start && ((state_r == IDLE) || (state_r == DONE));

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (CLOCK_50),
        .rst_n      (RESET_L),
        .clr        (start_acc_s),
        .in_valid   (hs_s),
        .in_data    (byte_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s      = state_r;
        len_eff_s    = len_eff_r;
        idx_s        = idx_r;
        overflow_s   = overflow_r;
        checksum_s   = checksum_r;
        mem_we_s     = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        byte_ready_s = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    len_eff_s  = (len_words > DEPTH_W) ? DEPTH_W : len_words;
                    overflow_s = (len_words > DEPTH_W);
                    checksum_s = 32'd0;
                    idx_s      = '0;
                    if (!skip_clear) begin
                        state_s     = CLEAR;
                        mem_we_s    = 1'b1;
                        mem_addr_s  = '0;
                        mem_wdata_s = '0;
                    end else begin
                        state_s      = LOAD;
                        byte_ready_s = (len_eff_s != '0);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            CLEAR: begin
                // idx_r is the word being written this cycle
                if (idx_r == LAST_IDX) begin
                    state_s      = LOAD;
                    idx_s        = '0;
                    byte_ready_s = (len_eff_r != '0);
                end else begin
                    mem_we_s    = 1'b1;
                    idx_s       = idx_r + LEN_W'(1);
                    mem_addr_s  = word_to_byte_addr(idx_s);
                    mem_wdata_s = '0;
                end
            end
            LOAD: begin
                if (word_valid_s) begin
                    mem_we_s     = 1'b1;
                    mem_addr_s   = word_to_byte_addr(idx_r);
                    mem_wdata_s  = word_s;
                    checksum_s   = checksum_r + 32'(word_s);
                    idx_s        = idx_r + LEN_W'(1);
                    byte_ready_s = (idx_s < len_eff_r);
                end else if (idx_r == len_eff_r) begin
                    state_s = DONE;
                end else begin
                    byte_ready_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        core_hold_s = (state_s == DONE);
        done_s      = (state_s == DONE);
        busy_s      = (state_s == CLEAR) || (state_s == LOAD);
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_r      <= IDLE;
            len_eff_r    <= '0;
            idx_r        <= '0;
            overflow_r   <= 1'b0;
            checksum_r   <= 32'd0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            byte_ready_r <= 1'b0;
            core_hold_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            len_eff_r    <= len_eff_s;
            idx_r        <= idx_s;
            overflow_r   <= overflow_s;
            checksum_r   <= checksum_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            byte_ready_r <= byte_ready_s;
            core_hold_r  <= core_hold_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign byte_ready  = byte_ready_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign core_hold_L = core_hold_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign overflow    = overflow_r;
    assign checksum    = checksum_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios with random programs checked against a write-list model.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit / 1024-word instance
    logic        rst_l, start, skip_clear, byte_valid;
    logic [10:0] len_words;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, core_hold_l, busy, done, overflow;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, checksum;

    // 16-bit / 16-word instance
    logic        rst16_l, start16, skip16, bv16;
    logic [4:0]  len16;
    logic [7:0]  bd16;
    logic        br16, we16, hold16, busy16, done16, ovf16;
    logic [4:0]  addr16;
    logic [15:0] wdata16;
    logic [31:0] csum16;

    imem_loader dut (
        .CLOCK_50(clk), .RESET_L(rst_l), .start(start), .skip_clear(skip_clear),
        .len_words(len_words), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold_L(core_hold_l), .busy(busy), .done(done), .overflow(overflow),
        .checksum(checksum)
    );

    imem_loader #(.DATA_WIDTH(16), .WORD_ADDR_W(4)) dut16 (
        .CLOCK_50(clk), .RESET_L(rst16_l), .start(start16), .skip_clear(skip16),
        .len_words(len16), .byte_valid(bv16), .byte_data(bd16),
        .byte_ready(br16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
        .core_hold_L(hold16), .busy(busy16), .done(done16), .overflow(ovf16),
        .checksum(csum16)
    );

    int vectors = 0;
    int miscompares = 0;
    int bad_we = 0;
    logic [47:0] wq[$];
    logic [20:0] wq16[$];

    typedef struct {
        logic skip;
        int   len;
        logic gap;
        logic poke;
        logic exp_ovf;
        logic fixed;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Write monitors: capture every memory write, flag writes outside CLEAR/LOAD.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back({4'b0000, mem_addr, mem_wdata});
        if (we16 === 1'b1) wq16.push_back({addr16, wdata16});
        if (mem_we === 1'b1 && busy !== 1'b1) bad_we++;
        if (we16 === 1'b1 && busy16 !== 1'b1) bad_we++;
    end

    task automatic run_vec(input vec_t v, input int id, input logic [7:0] bq[$]);
        logic [47:0] exp_q[$];
        logic [31:0] w;
        int unsigned csum = 0;
        int len_eff, idx, cyc, first_hs, last_hs, nbad, wcount;
        len_eff = (v.len > 1024) ? 1024 : v.len;
        if (!v.skip)
            for (int i = 0; i < 1024; i++) exp_q.push_back({4'b0000, 12'(i * 4), 32'h0});
        for (int k = 0; k < len_eff; k++) begin
            w = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
            csum += w;
            exp_q.push_back({4'b0000, 12'(k * 4), w});
        end
        wq.delete();
        @(negedge clk);
        start = 1'b1; skip_clear = v.skip; len_words = 11'(v.len);
        @(negedge clk);
        start = 1'b0; skip_clear = 1'($urandom); len_words = 11'($urandom);
        check($sformatf("v%0d busy after start", id), 64'(busy), 64'(1));
        check($sformatf("v%0d core held", id), 64'(core_hold_l), 64'(0));
        check($sformatf("v%0d done low", id), 64'(done), 64'(0));
        idx = 0; cyc = 0; first_hs = -1; last_hs = -1;
        while (done !== 1'b1 && cyc < 20000) begin
            if (idx < bq.size() && (!v.gap || (cyc % 2 == 0))) begin
                byte_valid = 1'b1; byte_data = bq[idx];
            end else begin
                byte_valid = 1'b0; byte_data = 8'($urandom);
            end
            if (byte_valid && byte_ready === 1'b1) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                idx++;
            end
            start = v.poke && (cyc == 6);
            if (start) begin skip_clear = 1'b0; len_words = 11'd7; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("v%0d done reached", id), 64'(done), 64'(1));
        wcount = wq.size();
        // spare bytes offered in DONE must be ignored
        for (int c = 0; c < 3; c++) begin
            byte_valid = 1'b1; byte_data = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check($sformatf("v%0d no write in DONE", id), 64'(wq.size()), 64'(wcount));
        check($sformatf("v%0d write count", id), 64'(wq.size()), 64'(exp_q.size()));
        nbad = 0;
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            if (wq[i] !== exp_q[i]) begin
                if (nbad == 0) $display("v%0d first bad write #%0d: got %h want %h", id, i, wq[i], exp_q[i]);
                nbad++;
            end
        check($sformatf("v%0d bad writes", id), 64'(nbad), 64'(0));
        check($sformatf("v%0d bytes taken", id), 64'(idx), 64'(len_eff * 4));
        if (!v.gap && len_eff > 0)
            check($sformatf("v%0d no stall", id), 64'(last_hs - first_hs), 64'(len_eff * 4 - 1));
        check($sformatf("v%0d overflow", id), 64'(overflow), 64'(v.exp_ovf));
        check($sformatf("v%0d checksum", id), 64'(checksum), 64'(csum));
        check($sformatf("v%0d core released", id), 64'(core_hold_l), 64'(1));
        check($sformatf("v%0d ready low", id), 64'(byte_ready), 64'(0));
        check($sformatf("v%0d busy low", id), 64'(busy), 64'(0));
    endtask

    initial begin
        logic [7:0] bq[$];
        logic [20:0] e16[$];
        int idx, cyc, nbad;

        tbl[0] = '{skip: 1'b0, len: 0,    gap: 1'b0, poke: 1'b0, exp_ovf: 1'b0, fixed: 1'b0};
        tbl[1] = '{skip: 1'b1, len: 2,    gap: 1'b0, poke: 1'b0, exp_ovf: 1'b0, fixed: 1'b1};
        tbl[2] = '{skip: 1'b1, len: 1500, gap: 1'b0, poke: 1'b0, exp_ovf: 1'b1, fixed: 1'b0};
        tbl[3] = '{skip: 1'b1, len: 3,    gap: 1'b1, poke: 1'b1, exp_ovf: 1'b0, fixed: 1'b0};
        tbl[4] = '{skip: 1'b0, len: 5,    gap: 1'b1, poke: 1'b0, exp_ovf: 1'b0, fixed: 1'b0};
        tbl[5] = '{skip: 1'b1, len: 1024, gap: 1'b0, poke: 1'b0, exp_ovf: 1'b0, fixed: 1'b0};
        tbl[6] = '{skip: 1'b1, len: 1025, gap: 1'b0, poke: 1'b0, exp_ovf: 1'b1, fixed: 1'b0};
        tbl[7] = '{skip: 1'b1, len: 0,    gap: 1'b0, poke: 1'b0, exp_ovf: 1'b0, fixed: 1'b0};

        rst_l = 1'b0; start = 1'b0; skip_clear = 1'b0; len_words = 11'd0;
        byte_valid = 1'b0; byte_data = 8'd0;
        rst16_l = 1'b0; start16 = 1'b0; skip16 = 1'b0; len16 = 5'd0; bv16 = 1'b0; bd16 = 8'd0;
        repeat (3) @(negedge clk);
        check("reset core_hold_L", 64'(core_hold_l), 64'(0));
        check("reset mem_we", 64'(mem_we), 64'(0));
        check("reset byte_ready", 64'(byte_ready), 64'(0));
        check("reset done/busy", 64'({done, busy, overflow}), 64'(0));
        check("reset checksum", 64'(checksum), 64'(0));
        rst_l = 1'b1; rst16_l = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            bq.delete();
            if (tbl[t].fixed) begin
                bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
            end else begin
                for (int i = 0; i < tbl[t].len * 4; i++) bq.push_back(8'($urandom));
            end
            run_vec(tbl[t], t, bq);
            if (tbl[t].fixed) check("fixed checksum", 64'(checksum), 64'(32'h001000A6));
        end
        check("mem_we only while busy", 64'(bad_we), 64'(0));

        // Reset in the middle of word 1: word 0 written, partial word dropped.
        wq.delete();
        @(negedge clk);
        start = 1'b1; skip_clear = 1'b1; len_words = 11'd2;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 6 && cyc < 100) begin
            byte_valid = 1'b1; byte_data = 8'(8'h40 + idx);
            if (byte_ready === 1'b1) idx++;
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        rst_l = 1'b0;
        #1;
        check("midrst bytes sent", 64'(idx), 64'(6));
        check("midrst outputs", 64'({byte_ready, mem_we, core_hold_l, busy, done, overflow}), 64'(0));
        check("midrst addr/data", 64'({mem_addr, mem_wdata}), 64'(0));
        check("midrst checksum", 64'(checksum), 64'(0));
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        for (int c = 0; c < 4; c++) begin
            byte_valid = 1'b1; byte_data = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("midrst write count", 64'(wq.size()), 64'(1));
        check("midrst word0", 64'(wq[0]), 64'({16'h0000, 32'h43424140}));
        check("midrst core held", 64'(core_hold_l), 64'(0));

        bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_vec('{skip: 1'b1, len: 1, gap: 1'b0, poke: 1'b0, exp_ovf: 1'b0, fixed: 1'b0}, 8, bq);
        check("deadbeef write", 64'(wq[0]), 64'({16'h0000, 32'hDEADBEEF}));

        // 16-bit instance: 16-word clear at stride 2, then one word.
        wq16.delete();
        for (int i = 0; i < 16; i++) e16.push_back({5'(i * 2), 16'h0000});
        e16.push_back({5'd0, 16'h1234});
        @(negedge clk);
        start16 = 1'b1; skip16 = 1'b0; len16 = 5'd1;
        @(negedge clk);
        start16 = 1'b0;
        bq = '{8'h34, 8'h12};
        idx = 0; cyc = 0;
        while (done16 !== 1'b1 && cyc < 200) begin
            bv16 = (idx < 2); bd16 = (idx < 2) ? bq[idx] : 8'h00;
            if (bv16 && br16 === 1'b1) idx++;
            @(negedge clk);
            cyc++;
        end
        bv16 = 1'b0;
        check("w16 done", 64'(done16), 64'(1));
        check("w16 write count", 64'(wq16.size()), 64'(e16.size()));
        nbad = 0;
        for (int i = 0; i < wq16.size() && i < e16.size(); i++)
            if (wq16[i] !== e16[i]) nbad++;
        check("w16 bad writes", 64'(nbad), 64'(0));
        check("w16 checksum", 64'(csum16), 64'(32'h00001234));
        check("w16 overflow", 64'(ovf16), 64'(0));
        check("mem_we only while busy end", 64'(bad_we), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware program loader for the RISC-V core's instruction memory; replaces bench-side forcing of the address and instruction write-data nets.
- On a start pulse it holds the core in reset, optionally clears the whole memory to zero, then streams a program in from a byte source.
- Bytes are assembled little-endian into words and written to sequential byte addresses. On completion the core is released.
- Sits between the boot byte source (UART/JTAG bridge) and the instruction RAM write port.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- WORD_ADDR_W, 10, word-address width; DEPTH = 2**WORD_ADDR_W words (default 1024 words = 4096 bytes).
- BYTES (derived), DATA_WIDTH/8, bytes per word; address stride.
- BYTE_ADDR_W (derived), WORD_ADDR_W + $clog2(BYTES), width of mem_addr.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- RESET_L  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start request; accepted only in IDLE or DONE.
- skip_clear  in  1  sampled with start; 1 bypasses the CLEAR phase.
- len_words  in  WORD_ADDR_W+1  number of words to load; sampled with start.
- byte_valid  in  1  source byte valid.
- byte_data  in  8  source byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  BYTE_ADDR_W  byte address of the write.
- mem_wdata  out  DATA_WIDTH  write data.
- core_hold_L  out  1  0 holds the core in reset.
- busy  out  1  high in CLEAR or LOAD.
- done  out  1  high in DONE.
- overflow  out  1  len_words exceeded DEPTH on the last start.
- checksum  out  32  mod-2^32 sum of all words written in LOAD.

Behaviour:
- Reset values: state = IDLE; mem_we = 0; mem_addr = 0; mem_wdata = 0; byte_ready = 0; core_hold_L = 0; busy = 0; done = 0; overflow = 0; checksum = 0.
- IDLE:
  - core_hold_L = 0.
  - start -> latch skip_clear and len_eff = min(len_words, DEPTH); set overflow = (len_words > DEPTH); clear checksum and byte-lane counter.
  - Next state: CLEAR if skip_clear = 0, otherwise LOAD.
- CLEAR:
  - mem_we = 1 and mem_wdata = 0 for exactly DEPTH consecutive cycles.
  - mem_addr = 0, BYTES, 2*BYTES, ... , (DEPTH-1)*BYTES.
  - byte_ready = 0.
  - After the final write -> LOAD, word index reset to 0.
- LOAD:
  - If len_eff = 0 -> DONE the cycle after entry; no writes occur.
  - byte_ready = 1 while fewer than len_eff words have been accepted.
  - A handshake occurs on byte_valid & byte_ready. The k-th byte of a word fills bits [8k+7:8k].
  - The cycle after the BYTES-th byte is accepted: mem_we = 1, mem_wdata = the assembled word (held in a separate register), mem_addr = word_index*BYTES; checksum += word.
  - byte_ready stays high during that write cycle, so back-to-back bytes stream with no stall.
  - byte_ready drops in the cycle after the last word's final byte is accepted. After that word's write -> DONE.
  - Bytes presented while byte_ready = 0 are ignored.
- DONE:
  - core_hold_L = 1, done = 1; mem_we = 0.
  - Checksum and overflow hold.
  - start -> re-enter the IDLE start sequence: core_hold_L = 0 the next cycle, done = 0.
- start is ignored in CLEAR/LOAD.
- mem_we is never asserted outside CLEAR and LOAD.
- Addresses never wrap: the highest address written is (DEPTH-1)*BYTES.
- RESET_L low mid-operation: immediate return to reset values. A partial word is discarded, no further writes occur, and the core stays held.

Decomposition:
- Package imem_loader_pkg holds the state enum typedef (IDLE, CLEAR, LOAD, DONE) and a function bytes_per_word(DATA_WIDTH).
- One sub-module is natural: byte_packer (byte-lane counter plus little-endian assembly register, word_valid output).
- Everything else stays in the top FSM.

Test Plan:
- Reset with defaults -> core_hold_L=0, mem_we=0, byte_ready=0; start, skip_clear=0, len_words=0 -> 1024 writes of 0 at addresses 0x000..0xFFC, then done=1, core_hold_L=1, checksum=0.
- skip_clear=1, len_words=2, bytes 13 00 00 00 93 00 10 00 driven back-to-back -> writes 0x00000013@0x000 and 0x00100093@0x004, no stall cycles, checksum=0x001000A6, then DONE.
- len_words=1500 -> overflow=1, exactly 1024 words loaded, last write at 0xFFC, byte_ready=0 afterwards.
- byte_valid toggling every other cycle, len_words=3 -> write addresses 0x000/0x004/0x008 with correct data; start pulses during LOAD are ignored.
- RESET_L low after 2 bytes of word 1 -> all outputs at reset values, no write for the partial word. New start with skip_clear=1, len_words=1, bytes EF BE AD DE -> 0xDEADBEEF@0x000.
- DATA_WIDTH=16, WORD_ADDR_W=4 -> CLEAR writes 16 words at stride 2 (0x00..0x1E); bytes 34 12 -> 0x1234@0x00.
